// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants for the address decoder and its default slave.
package ahb_pkg;

  localparam int REGION_W = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic htrans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped regions: answers active transfers with a
// two-cycle ERROR response and IDLE/BUSY with a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      start;

  assign start = HREADY && HSEL && htrans_active(HTRANS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ERR1 ignores HTRANS so the error sequence always runs to completion.
  always_comb begin
    state_d = DS_IDLE;
    case (state_q)
      DS_ERR1: state_d = DS_ERR2;
      default: state_d = start ? DS_ERR1 : DS_IDLE;
    endcase
  end

  // Outputs depend on state only, which keeps the HREADY feedback loop open.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      DS_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave-to-master response mux with a built-in
// default slave; the region field sits at HADDR[SEL_LSB+3:SEL_LSB].
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLAVES = 7,
  parameter int                    SEL_LSB    = 28,
  parameter logic [NUM_SLAVES-1:0] REGION_EN  = {NUM_SLAVES{1'b1}}
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [NUM_SLAVES-1:0]    HSEL,
  input  logic [32*NUM_SLAVES-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]    S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]    S_HRESP,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int NUM_REGIONS = 2 ** REGION_W;

  logic [REGION_W-1:0]    region;
  logic [NUM_REGIONS-1:0] en_map;
  logic                   mapped;
  logic                   unused_addr;

  logic                   dflt_q, dflt_d;
  logic [REGION_W-1:0]    idx_q, idx_d;
  logic                   ds_hreadyout;
  logic                   ds_hresp;

  assign region      = HADDR[SEL_LSB +: REGION_W];
  assign unused_addr = ^(HADDR & ~(32'hF << SEL_LSB));

  // Regions past NUM_SLAVES are forced unmapped so any 4-bit index is safe.
  generate
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_en
      if (gi < NUM_SLAVES) begin : g_on
        assign en_map[gi] = REGION_EN[gi];
      end else begin : g_off
        assign en_map[gi] = 1'b0;
      end
    end
  endgenerate

  assign mapped = en_map[region];

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hsel
      assign HSEL[gi] = mapped && (region == REGION_W'(gi));
    end
  endgenerate

  always_comb begin
    dflt_d = dflt_q;
    idx_d  = idx_q;
    if (HREADY) begin
      dflt_d = ~mapped;
      idx_d  = region;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dflt_q <= 1'b1;
      idx_q  <= '0;
    end else begin
      dflt_q <= dflt_d;
      idx_q  <= idx_d;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (~mapped),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = ds_hreadyout;
    HRESP  = ds_hresp;
    if (!dflt_q) begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      for (int n = 0; n < NUM_SLAVES; n++) begin
        if (idx_q == REGION_W'(n)) begin
          HRDATA = S_HRDATA[32*n +: 32];
          HREADY = S_HREADYOUT[n];
          HRESP  = S_HRESP[n];
        end
      end
    end
  end

endmodule

// File: doc/ahb_decode_mux.md
AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 SHALL take parameter NUM_SLAVES, default 7, the number of mapped slave ports; legal range 1..15.
REQ-002 SHALL take parameter SEL_LSB, default 28, the lowest HADDR bit of the 4-bit region field HADDR[SEL_LSB+3:SEL_LSB].
REQ-003 SHALL take parameter REGION_EN, default {NUM_SLAVES{1'b1}}, a per-slot enable mask; bit n=0 unmaps slot n.
REQ-004 HCLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 HRESET  in  1  reset, synchronous, active-high.
REQ-006 HADDR  in  32  master address-phase address.
REQ-007 HTRANS  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 HSEL  out  NUM_SLAVES  per-slave address-phase select, one-hot or zero.
REQ-009 S_HRDATA  in  32*NUM_SLAVES  slave read data, slave n at bits [32n+31:32n].
REQ-010 S_HREADYOUT  in  NUM_SLAVES  slave ready outputs.
REQ-011 S_HRESP  in  NUM_SLAVES  slave responses (1=ERROR).
REQ-012 HRDATA  out  32  muxed read data to master.
REQ-013 HREADY  out  1  muxed ready to master, also fed back to all slaves.
REQ-014 HRESP  out  1  muxed response to master.

Function
REQ-015 Region index r=HADDR[SEL_LSB+3:SEL_LSB]; slot r is mapped iff r<NUM_SLAVES and REGION_EN[r]=1.
REQ-016 HSEL[r] SHALL be 1 combinationally when slot r is mapped, independent of HTRANS; all other bits 0.
REQ-017 An unmapped r SHALL select the internal default slave and drive HSEL=0.
REQ-018 A data-phase select register (slot index plus default flag) SHALL load the address-phase decode on every HCLK edge where HREADY=1 and hold otherwise.
REQ-019 Data phase, mapped slot n: HRDATA=S_HRDATA[n], HREADY=S_HREADYOUT[n], HRESP=S_HRESP[n], zero added latency.
REQ-020 Default slave FSM states: IDLE, ERR1, ERR2.
REQ-021 IDLE->ERR1 when HREADY=1, default selected, and HTRANS is NONSEQ or SEQ; otherwise stay IDLE.
REQ-022 ERR1->ERR2 unconditionally; ERR2 follows the IDLE transition rule, so back-to-back unmapped transfers re-enter ERR1.
REQ-023 Outputs with default selected: IDLE gives HREADY=1 and HRESP=0; ERR1 gives HREADY=0 and HRESP=1; ERR2 gives HREADY=1 and HRESP=1; HRDATA=0 in all three states.
REQ-024 IDLE or BUSY to an unmapped region SHALL complete zero-wait OKAY.
REQ-025 HTRANS changes during ERR1 SHALL NOT alter the two-cycle error sequence.
REQ-026 The data-phase select SHALL NOT change while HREADY=0 (slave wait states or ERR1).

Reset
REQ-027 With HRESET=1 at an HCLK edge, the data-phase select SHALL become the default slave and the FSM SHALL become IDLE.
REQ-028 Outputs after reset: HREADY=1, HRESP=0, HRDATA=0; HSEL stays combinational from HADDR.
REQ-029 Reset asserted mid-ERR1/ERR2 or during a slave wait state SHALL abort to the REQ-027 state on that edge.

Structure
REQ-030 Shared package ahb_pkg SHALL hold the HTRANS encodings, HRESP encodings and the region-field width constant (4).
REQ-031 The default-slave FSM SHALL be sub-module ahb_default_slave (HCLK, HRESET, HSEL, HTRANS, HREADY in; HREADYOUT, HRESP out).
REQ-032 The decode logic and data mux SHALL remain in ahb_decode_mux.

Verification
REQ-033 Run 1 uses the defaults. HADDR=0x3000_0000 NONSEQ -> HSEL=0x08; next cycle HRDATA=S_HRDATA[3], HREADY=S_HREADYOUT[3].
REQ-034 Run 2 uses the defaults. HADDR=0x8000_0000 NONSEQ -> HSEL=0; then HREADY=0, HRESP=1; then HREADY=1, HRESP=1; then OKAY.
REQ-035 Run 3 uses the defaults. HADDR=0xF000_0000 IDLE -> HSEL=0; next cycle HREADY=1, HRESP=0.
REQ-036 Run 4 uses the defaults. Slave 2 holds S_HREADYOUT=0 for 3 cycles while HADDR moves to 0x5000_0000 -> mux stays on slave 2 for all 3 cycles, then switches to slave 5.
REQ-037 Run 5 uses REGION_EN=7'b1111011. HADDR=0x2000_0000 NONSEQ -> HSEL=0 and the two-cycle ERROR sequence.
REQ-038 Run 6 uses the defaults. HRESET=1 during ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0.
